// File: rtl/q_sys_lut_pkg.sv
// Shared constants for the LUT load controller: register map, bit fields, FSM.
// Optional checksum read-back is enabled by defining Q_SYS_LUT_CHECKSUM_EN.
package q_sys_lut_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_AUTO_INC = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_SEL_LO   = 4;
    localparam int CTRL_FLUSH    = 31;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_DONE  = 4;
    localparam int ST_ERR   = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/q_sys_lut_fifo.sv
// Synchronous push FIFO with flush; a push while full is refused.
// Fullness is judged before any same-cycle pop.
module q_sys_lut_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/q_sys_lut_load_ctrl.sv
// Avalon-MM LUT loader: buffered pushes drained into handshaked LUT writes.
// Define Q_SYS_LUT_CHECKSUM_EN to read a running sum of accepted words at offset 0.
module q_sys_lut_load_ctrl
    import q_sys_lut_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int SEL_W      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [SEL_W-1:0]  lut_sel,
    output logic [ADDR_W-1:0] lut_addr,
    output logic [DATA_W-1:0] lut_data,
    output logic              lut_we,
    input  logic              lut_ready,
    output logic              irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              auto_inc;
    logic              irq_en;
    logic              overflow;
    logic              done;
    logic              cmd_err;
    logic              wr_data;
    logic              wr_addr;
    logic              wr_ctrl;
    logic              wr_status;
    logic              flush;
    logic              busy;
    logic              accept;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic [LW-1:0]     level;

    assign wr_data   = chipselect & ~write_n & (address == REG_DATA);
    assign wr_addr   = chipselect & ~write_n & (address == REG_ADDR);
    assign wr_ctrl   = chipselect & ~write_n & (address == REG_CTRL);
    assign wr_status = chipselect & ~write_n & (address == REG_STATUS);
    assign flush     = wr_ctrl & writedata[CTRL_FLUSH];
    assign busy      = (state == WRITE) | ~empty;
    assign accept    = (state == WRITE) & lut_ready;
    assign pop       = ~empty & ((state == IDLE) | accept);
    assign next_addr = cur_addr + ADDR_W'(auto_inc);

    q_sys_lut_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_data),
        .pop     (pop),
        .flush   (flush),
        .wdata   (writedata[DATA_W-1:0]),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            lut_addr <= '0;
            lut_data <= '0;
            lut_we   <= 1'b0;
            lut_sel  <= '0;
            auto_inc <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
            cmd_err  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        lut_addr <= cur_addr;
                        lut_data <= head;
                        lut_we   <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (lut_ready) begin
                        cur_addr <= next_addr;
                        if (!empty) begin
                            lut_addr <= next_addr;
                            lut_data <= head;
                        end else begin
                            lut_we <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (wr_addr && !busy) begin
                cur_addr <= writedata[ADDR_W-1:0];
            end
            if (wr_ctrl) begin
                auto_inc <= writedata[CTRL_AUTO_INC];
                irq_en   <= writedata[CTRL_IRQ_EN];
                if (!busy) lut_sel <= writedata[CTRL_SEL_LO +: SEL_W];
            end
            // Clears from STATUS writes lose to events in the same cycle.
            overflow <= (overflow & ~(wr_status & writedata[ST_OVF]))
                      | (wr_data & full);
            done     <= (done & ~(wr_status & writedata[ST_DONE]))
                      | (accept & empty);
            cmd_err  <= (cmd_err & ~(wr_status & writedata[ST_ERR]))
                      | (busy & (wr_addr | wr_ctrl));
            irq      <= irq_en & (done | overflow | cmd_err);
        end
    end

`ifdef Q_SYS_LUT_CHECKSUM_EN
    logic [31:0] checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (flush || (wr_addr && !busy)) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + 32'(lut_data);
        end
    end
`endif

    always_comb begin
        readdata = '0;
        unique case (address)
            REG_DATA: begin
`ifdef Q_SYS_LUT_CHECKSUM_EN
                readdata = checksum;
`else
                readdata = 32'(level);
`endif
            end
            REG_ADDR: readdata = 32'(cur_addr);
            REG_CTRL: begin
                readdata[CTRL_AUTO_INC]         = auto_inc;
                readdata[CTRL_IRQ_EN]           = irq_en;
                readdata[CTRL_SEL_LO +: SEL_W]  = lut_sel;
            end
            default: begin
                readdata[ST_BUSY]  = busy;
                readdata[ST_FULL]  = full;
                readdata[ST_EMPTY] = empty;
                readdata[ST_OVF]   = overflow;
                readdata[ST_DONE]  = done;
                readdata[ST_ERR]   = cmd_err;
            end
        endcase
    end

endmodule
